register_bank_sb: RTL

- Parametrised successor to the 8x8 register bank: configurable width and depth, separate write address, and an optional write-to-read bypass.
- Adds a per-register pending scoreboard, so the control unit can stall on operands whose producer has not written back yet.
- Adds a sequential bulk-clear engine.
- Sits between the decoder/control FSM and the ALU datapath.

---
 rtl/register_bank_sb.sv | 116 +++++++++++
 1 files changed

// File: rtl/register_bank_sb.sv
// Parametrised register bank with a pending-operand scoreboard, optional
// write-to-read bypass and a sequential bulk-clear engine.
module register_bank_sb #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_en,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] in_wr_selector,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_rx_selector,
  input  logic [ADDR_W-1:0] in_ry_selector,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] in_issue_selector,
  input  logic              clear_start,
  output logic [DATA_W-1:0] out_r0_data,
  output logic [DATA_W-1:0] out_rx_data,
  output logic [DATA_W-1:0] out_ry_data,
  output logic              out_rx_pending,
  output logic              out_ry_pending,
  output logic              out_stall,
  output logic              out_clear_busy,
  output logic              out_write_err
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_CLEAR = 1'b1;

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_pending;
  logic                r_state;
  logic [ADDR_W-1:0]   r_clrIdx;
  logic                r_writeErr;

  logic              w_idle;
  logic              w_wrAcc;
  logic              w_issAcc;
  logic              w_rxByp;
  logic              w_ryByp;
  logic              w_r0Byp;
  logic [DATA_W-1:0] w_r0Data;

  // Gating with rst_n keeps the bypass from leaking in_data while in reset.
  assign w_idle   = (r_state == ST_IDLE);
  assign w_wrAcc  = write_en & w_idle & rst_n;
  assign w_issAcc = issue_en & w_idle & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_pending  <= '0;
      r_state    <= ST_IDLE;
      r_clrIdx   <= '0;
      r_writeErr <= 1'b0;
    end else begin
      r_writeErr <= ~w_idle & (write_en | issue_en);
      if (w_idle) begin
        if (write_en) begin
          r_regs[in_wr_selector]    <= in_data;
          r_pending[in_wr_selector] <= 1'b0;
        end
        // Issue is the newer producer, so it overrides a same-register write.
        if (issue_en) begin
          r_pending[in_issue_selector] <= 1'b1;
        end
        if (clear_start) begin
          r_state  <= ST_CLEAR;
          r_clrIdx <= '0;
        end
      end else begin
        r_regs[r_clrIdx]    <= '0;
        r_pending[r_clrIdx] <= 1'b0;
        r_clrIdx            <= r_clrIdx + ADDR_W'(1);
        if (r_clrIdx == ADDR_W'(NUM_REGS - 1)) begin
          r_state <= ST_IDLE;
        end
      end
    end
  end

  assign w_rxByp = (BYPASS != 0) && w_wrAcc && (in_wr_selector == in_rx_selector);
  assign w_ryByp = (BYPASS != 0) && w_wrAcc && (in_wr_selector == in_ry_selector);
  assign w_r0Byp = (BYPASS != 0) && w_wrAcc && (in_wr_selector == '0);

  always_comb begin
    out_rx_data    = r_regs[in_rx_selector];
    out_rx_pending = r_pending[in_rx_selector];
    out_ry_data    = r_regs[in_ry_selector];
    out_ry_pending = r_pending[in_ry_selector];
    w_r0Data       = r_regs[0];
    if (w_rxByp) begin
      out_rx_data    = in_data;
      out_rx_pending = w_issAcc && (in_issue_selector == in_rx_selector);
    end
    if (w_ryByp) begin
      out_ry_data    = in_data;
      out_ry_pending = w_issAcc && (in_issue_selector == in_ry_selector);
    end
    if (w_r0Byp) begin
      w_r0Data = in_data;
    end
  end

  assign out_r0_data    = read_en ? w_r0Data : {DATA_W{1'bz}};
  assign out_stall      = out_rx_pending | out_ry_pending;
  assign out_clear_busy = (r_state == ST_CLEAR);
  assign out_write_err  = r_writeErr;

endmodule
